// File: rtl/char_sweep_pkg.sv
// rtl/char_sweep_pkg.sv - shared types and helpers for the characterization sweep sequencer
// Holds the FSM state encoding, the arc encoding and the result address width helper.
package char_sweep_pkg;

   localparam int ARC_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_CFG_SETTLE,
      ST_TOGGLE,
      ST_SETTLE,
      ST_MEAS,
      ST_WRITE,
      ST_DONE
   } state_t;

   typedef enum logic [ARC_W-1:0] {
      A1_FALL = 2'd0,
      A1_RISE = 2'd1,
      A2_FALL = 2'd2,
      A2_RISE = 2'd3
   } arc_t;

   // Result address is {arc, slope_idx, capa_idx}.
   function automatic int res_addr_w(input int idx_w);
      return ARC_W + 2 * idx_w;
   endfunction

endpackage

// File: rtl/char_sweep_if.sv
// rtl/char_sweep_if.sv - sweep control, stimulus, measurement and result-write signal bundle
// master = sequencer side, slave = front end / result RAM / host side.
interface char_sweep_if #(
   parameter int IDX_W  = 3,
   parameter int DATA_W = 32
);

   localparam int ADDR_W = char_sweep_pkg::res_addr_w(IDX_W);

   logic              start;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  slope_idx;
   logic [IDX_W-1:0]  capa_idx;
   logic              cfg_load;
   logic              din1;
   logic              din2;
   logic              meas_req;
   logic              meas_ack;
   logic [DATA_W-1:0] meas_data;
   logic              res_we;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_data;
   logic              timeout_err;

   modport master (
      input  start,
      input  meas_ack,
      input  meas_data,
      output busy,
      output done,
      output slope_idx,
      output capa_idx,
      output cfg_load,
      output din1,
      output din2,
      output meas_req,
      output res_we,
      output res_addr,
      output res_data,
      output timeout_err
   );

   modport slave (
      output start,
      output meas_ack,
      output meas_data,
      input  busy,
      input  done,
      input  slope_idx,
      input  capa_idx,
      input  cfg_load,
      input  din1,
      input  din2,
      input  meas_req,
      input  res_we,
      input  res_addr,
      input  res_data,
      input  timeout_err
   );

endinterface

// File: rtl/char_settle_timer.sv
// rtl/char_settle_timer.sv - loadable down-counter shared by settle and measurement-timeout waits
// Loading N-1 on start makes expired rise on the Nth cycle after the load.
module char_settle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/char_sweep_ctrl.sv
// rtl/char_sweep_ctrl.sv - slope x load grid sequencer driving four input arcs per point
// Optional measurement timeout is enabled by defining CHAR_SWEEP_TIMEOUT_EN.
module char_sweep_ctrl
   import char_sweep_pkg::*;
#(
   parameter int NB_SLOPES   = 7,
   parameter int NB_CAPA     = 7,
   parameter int IDX_W       = 3,
   parameter int SETTLE_CYC  = 7,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic         clk,
   input  logic         rst,
   char_sweep_if.master bus
);

   if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1 ||
       (1 << IDX_W) < NB_SLOPES || (1 << IDX_W) < NB_CAPA) begin : g_bad_params
      $error("char_sweep_ctrl: invalid parameter set");
   end

`ifdef CHAR_SWEEP_TIMEOUT_EN
   localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
`else
   localparam int TMR_MAX = SETTLE_CYC;
`endif
   localparam int TMR_W = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
`ifdef CHAR_SWEEP_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);
`endif
   localparam logic [IDX_W-1:0] LAST_SLOPE = IDX_W'(NB_SLOPES - 1);
   localparam logic [IDX_W-1:0] LAST_CAPA  = IDX_W'(NB_CAPA - 1);

   state_t            state_q, state_d;
   arc_t              arc_q, arc_d;
   logic [IDX_W-1:0]  slope_q, slope_d;
   logic [IDX_W-1:0]  capa_q, capa_d;
   logic              din1_q, din1_d;
   logic              din2_q, din2_d;
   logic [DATA_W-1:0] data_q, data_d;
`ifdef CHAR_SWEEP_TIMEOUT_EN
   logic              timeout_err_q, timeout_err_d;
`endif

   logic             tmr_start;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expired;

   char_settle_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (tmr_start),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      arc_d     = arc_q;
      slope_d   = slope_q;
      capa_d    = capa_q;
      din1_d    = din1_q;
      din2_d    = din2_q;
      data_d    = data_q;
`ifdef CHAR_SWEEP_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif
      tmr_start = 1'b0;
      tmr_val   = SETTLE_LOAD;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_CFG;
               arc_d   = A1_FALL;
               slope_d = '0;
               capa_d  = '0;
`ifdef CHAR_SWEEP_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end
         end
         ST_CFG: begin
            tmr_start = 1'b1;
            state_d   = ST_CFG_SETTLE;
         end
         ST_CFG_SETTLE: begin
            if (tmr_expired) begin
               state_d = ST_TOGGLE;
            end
         end
         ST_TOGGLE: begin
            // din flops update at the end of this cycle, so the edge lands in SETTLE.
            case (arc_q)
               A1_FALL: din1_d = 1'b0;
               A1_RISE: din1_d = 1'b1;
               A2_FALL: din2_d = 1'b0;
               A2_RISE: din2_d = 1'b1;
            endcase
            tmr_start = 1'b1;
            state_d   = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (tmr_expired) begin
               state_d = ST_MEAS;
`ifdef CHAR_SWEEP_TIMEOUT_EN
               tmr_start = 1'b1;
               tmr_val   = TIMEOUT_LOAD;
`endif
            end
         end
         ST_MEAS: begin
            if (bus.meas_ack) begin
               data_d  = bus.meas_data;
               state_d = ST_WRITE;
`ifdef CHAR_SWEEP_TIMEOUT_EN
            end else if (tmr_expired) begin
               data_d        = '1;
               timeout_err_d = 1'b1;
               state_d       = ST_WRITE;
`endif
            end
         end
         ST_WRITE: begin
            if (arc_q != A2_RISE) begin
               arc_d   = arc_t'(arc_q + 2'd1);
               state_d = ST_TOGGLE;
            end else begin
               arc_d = A1_FALL;
               if (slope_q == LAST_SLOPE && capa_q == LAST_CAPA) begin
                  slope_d = '0;
                  capa_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CFG;
                  if (capa_q == LAST_CAPA) begin
                     capa_d  = '0;
                     slope_d = slope_q + 1'b1;
                  end else begin
                     capa_d = capa_q + 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         arc_q   <= A1_FALL;
         slope_q <= '0;
         capa_q  <= '0;
         din1_q  <= 1'b1;
         din2_q  <= 1'b1;
         data_q  <= '0;
`ifdef CHAR_SWEEP_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         arc_q   <= arc_d;
         slope_q <= slope_d;
         capa_q  <= capa_d;
         din1_q  <= din1_d;
         din2_q  <= din2_d;
         data_q  <= data_d;
`ifdef CHAR_SWEEP_TIMEOUT_EN
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.cfg_load  = (state_q == ST_CFG);
   assign bus.meas_req  = (state_q == ST_MEAS);
   assign bus.res_we    = (state_q == ST_WRITE);
   assign bus.res_addr  = (state_q == ST_WRITE) ? {arc_q, slope_q, capa_q} : '0;
   assign bus.res_data  = (state_q == ST_WRITE) ? data_q : '0;
   assign bus.slope_idx = slope_q;
   assign bus.capa_idx  = capa_q;
   assign bus.din1      = din1_q;
   assign bus.din2      = din2_q;
`ifdef CHAR_SWEEP_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule
